issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised successor of the combinational issue stage. It buffers decoded instructions in a DEPTH-entry FIFO and wakes buffered operands from CDB_N broadcast channels every cycle. It dispatches the head in order, at most one per cycle, to the reservation station or load/store buffer, but only when the ROB and the target unit both have space. It sits between decode and RS/LSB/ROB and drives the register-file lock.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ROB_W, 4, ROB tag width
- DATA_W, 32, operand width
- CDB_N, 2, number of broadcast channels (ALU, LSB, …)

- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  misprediction flush
- dec_valid / dec_ready  in / out  1 / 1  decode handshake
- dec_op  in  OP_W  op code
- dec_rd  in  5  destination register
- dec_imm  in  32  immediate
- dec_pc  in  32  PC
- dec_rs1_q, dec_rs2_q  in  1  operand pending in ROB
- dec_rs1_v, dec_rs2_v  in  DATA_W  value, or ROB tag in low ROB_W bits when q=1
- cdb_valid  in  CDB_N  channel valid
- cdb_tag  in  CDB_N·ROB_W  broadcast tags
- cdb_val  in  CDB_N·DATA_W  broadcast values
- rob_avail, rs_avail, lsb_avail  in  1  space available
- rob_tag  in  ROB_W  tag the ROB allocates on push
- iss_valid  out  1  dispatch pulse
- iss_to_rs, iss_to_lsb, iss_lock  out  1  targets; iss_lock = lock rd with iss_robtag
- iss_op  out  OP_W  op code
- iss_rd  out  5  destination register
- iss_imm  out  32  immediate
- iss_pc  out  32  PC
- iss_robtag  out  ROB_W  allocated ROB tag
- iss_vj, iss_vk  out  DATA_W  operand values
- iss_qj, iss_qk  out  1  operand pending
- iss_tj, iss_tk  out  ROB_W  pending tags

## Operation
- Op class (from the shared package):
  - LOAD, STORE → LSB.
  - BRANCH, ALU (incl. LUI/AUIPC/JAL/JALR) → RS.
  - Both precedence cases are decided explicitly: a store never goes to the RS; a branch needs rs_avail.
- Enqueue: dec_valid && dec_ready && rdy_in && !flush_in, where dec_ready = (count != DEPTH).
  - Each incoming q=1 operand is compared against all CDB channels in the same cycle.
  - On a match it is stored with q=0 and the value.
- Wake-up: every cycle, each valid entry operand with q=1 and tag == cdb_tag[i] && cdb_valid[i] captures cdb_val[i] and clears q.
  - If several channels match, the lowest index wins.
- Dispatch condition: count != 0 && rob_avail && (class RS ? rs_avail : lsb_avail).
- On dispatch:
  - The head is popped and the iss_* registers are loaded.
  - Head operands also see same-cycle CDB matches (bypass), so a value broadcast in the dispatch cycle is never lost.
  - iss_robtag = rob_tag.
  - iss_lock = (class ALU or LOAD) && rd != 0.
- Simultaneous enqueue and dispatch: count unchanged. Pointers wrap modulo DEPTH.
- Flush:
  - Clears count and both pointers, and forces iss_valid=0 at the next edge.
  - Flush has priority over enqueue, dispatch and wake-up.
- rdy_in=0: no state changes; iss_valid=0 next cycle.

## Timing
- Reset values:
  - count, head and tail pointers = 0.
  - All entry valid bits = 0.
  - iss_valid, iss_to_rs, iss_to_lsb, iss_lock, iss_qj, iss_qk = 0.
  - All iss_* data outputs = 0.
  - dec_ready = 1.
- Latency: an instruction accepted at edge t is dispatchable at edge t+1, so iss_valid is high in the cycle after t+1. The minimum is 2 edges from decode to issue outputs.
- iss_valid is a single-cycle pulse per instruction. iss_* are registered and held until the next dispatch (only iss_valid drops).
- dec_ready depends on registered count only; there is no combinational path from dec_valid.
- rob_avail, rs_avail and lsb_avail are sampled in the dispatch cycle; the consumer pushes on iss_valid.
- Reset asserted mid-operation empties the queue immediately (asynchronous).

## Structure
- def.v holds:
  - op encodings and OP_W;
  - op-class constants (CLS_ALU, CLS_BR, CLS_LD, CLS_ST);
  - the op-to-class function.
- Sub-module issue_wakeup: one operand vs CDB_N channels. Inputs q, v, cdb_*; outputs new q and v.
  - Instantiated per stored operand and at the enqueue and dispatch bypass points.
- Storage is flat registers per entry: valid, op, rd, imm, pc, q1, v1, q2, v2.

## Test plan
- Reset then 4 back-to-back ALU ops (ADDI rd=1..4) with rob_avail=rs_avail=1 → iss_valid on cycles 2–5, iss_to_rs=1, iss_lock=1, iss_robtag follows rob_tag.
- Hold rs_avail=0 while enqueuing DEPTH ops → dec_ready=0 after the 4th, no iss_valid. Raising rs_avail drains in order, one per cycle.
- Enqueue ADD with rs1_q=1, tag 5; after 3 cycles drive cdb_valid[1]=1, tag 5, val 0x1234 → the later dispatch shows iss_qj=0, iss_vj=0x1234.
- The CDB broadcast of tag 7 occurs in the same cycle as enqueue, and in a separate case in the same cycle as dispatch → both give iss_qk=0 with the broadcast value.
- SW with lsb_avail=1, rs_avail=0 → iss_to_lsb=1, iss_lock=0. BEQ with rs_avail=0 → no dispatch.
- Fill 3 entries, assert flush_in together with dec_valid → count=0, no iss_valid next cycle, dec_ready=1.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: op encodings, op classes and the op-to-class decoder shared by the issue stage
package issue_queue_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;
    localparam logic [OP_W-1:0] OP_LB    = 6'd10;
    localparam logic [OP_W-1:0] OP_LH    = 6'd11;
    localparam logic [OP_W-1:0] OP_LW    = 6'd12;
    localparam logic [OP_W-1:0] OP_LBU   = 6'd13;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd14;
    localparam logic [OP_W-1:0] OP_SB    = 6'd15;
    localparam logic [OP_W-1:0] OP_SH    = 6'd16;
    localparam logic [OP_W-1:0] OP_SW    = 6'd17;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd18;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd20;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd21;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd22;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd23;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd26;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd27;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd28;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd31;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd32;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd34;
    localparam logic [OP_W-1:0] OP_OR    = 6'd35;
    localparam logic [OP_W-1:0] OP_AND   = 6'd36;

    typedef enum logic [1:0] {CLS_ALU, CLS_BR, CLS_LD, CLS_ST} op_cls_e;

    // Branches, loads and stores occupy contiguous code ranges; everything else is ALU work
    function automatic op_cls_e op_class(input logic [OP_W-1:0] op);
        return (op inside {[OP_BEQ:OP_BGEU]}) ? CLS_BR :
               (op inside {[OP_LB:OP_LHU]})   ? CLS_LD :
               (op inside {[OP_SB:OP_SW]})    ? CLS_ST : CLS_ALU;
    endfunction

endpackage

// File: rtl/issue_queue_wakeup.sv
// issue_wakeup: resolves one pending operand against all CDB broadcast channels
module issue_wakeup #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int CDB_N  = 2
) (
    input  logic                      q_i,
    input  logic [DATA_W-1:0]         v_i,
    input  logic [CDB_N-1:0]          cdb_valid_i,
    input  logic [CDB_N*ROB_W-1:0]    cdb_tag_i,
    input  logic [CDB_N*DATA_W-1:0]   cdb_val_i,
    output logic                      q_o,
    output logic [DATA_W-1:0]         v_o
);

    // Scan high to low so the lowest matching channel is the one that sticks
    always_comb begin
        q_o = q_i;
        v_o = v_i;
        for (int i = CDB_N - 1; i >= 0; i--)
            if (q_i && cdb_valid_i[i] && cdb_tag_i[i*ROB_W +: ROB_W] == v_i[ROB_W-1:0]) begin
                q_o = 1'b0;
                v_o = cdb_val_i[i*DATA_W +: DATA_W];
            end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order FIFO between decode and RS/LSB/ROB with CDB operand wake-up
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int CDB_N  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [OP_W-1:0]         dec_op,
    input  logic [4:0]              dec_rd,
    input  logic [31:0]             dec_imm,
    input  logic [31:0]             dec_pc,
    input  logic                    dec_rs1_q,
    input  logic                    dec_rs2_q,
    input  logic [DATA_W-1:0]       dec_rs1_v,
    input  logic [DATA_W-1:0]       dec_rs2_v,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_val,
    input  logic                    rob_avail,
    input  logic                    rs_avail,
    input  logic                    lsb_avail,
    input  logic [ROB_W-1:0]        rob_tag,
    output logic                    iss_valid,
    output logic                    iss_to_rs,
    output logic                    iss_to_lsb,
    output logic                    iss_lock,
    output logic [OP_W-1:0]         iss_op,
    output logic [4:0]              iss_rd,
    output logic [31:0]             iss_imm,
    output logic [31:0]             iss_pc,
    output logic [ROB_W-1:0]        iss_robtag,
    output logic [DATA_W-1:0]       iss_vj,
    output logic [DATA_W-1:0]       iss_vk,
    output logic                    iss_qj,
    output logic                    iss_qk,
    output logic [ROB_W-1:0]        iss_tj,
    output logic [ROB_W-1:0]        iss_tk
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic [DEPTH-1:0]  valid_q, q1_q, q2_q, w_q1, w_q2;
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [4:0]        rd_q  [DEPTH];
    logic [31:0]       imm_q [DEPTH];
    logic [31:0]       pc_q  [DEPTH];
    logic [DATA_W-1:0] v1_q  [DEPTH];
    logic [DATA_W-1:0] v2_q  [DEPTH];
    logic [DATA_W-1:0] w_v1  [DEPTH];
    logic [DATA_W-1:0] w_v2  [DEPTH];
    logic              eq1, eq2;
    logic [DATA_W-1:0] ev1, ev2;
    op_cls_e           head_cls;
    logic              to_rs, enq, disp;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        issue_wakeup #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_w1 (
            .q_i(q1_q[e]), .v_i(v1_q[e]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_val_i(cdb_val), .q_o(w_q1[e]), .v_o(w_v1[e]));
        issue_wakeup #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_w2 (
            .q_i(q2_q[e]), .v_i(v2_q[e]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_val_i(cdb_val), .q_o(w_q2[e]), .v_o(w_v2[e]));
    end

    issue_wakeup #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_enq1 (
        .q_i(dec_rs1_q), .v_i(dec_rs1_v), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_val_i(cdb_val), .q_o(eq1), .v_o(ev1));
    issue_wakeup #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_enq2 (
        .q_i(dec_rs2_q), .v_i(dec_rs2_v), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_val_i(cdb_val), .q_o(eq2), .v_o(ev2));

    assign dec_ready = count_q != (PW+1)'(DEPTH);
    assign head_cls  = op_class(op_q[head_q]);
    assign to_rs     = head_cls == CLS_ALU || head_cls == CLS_BR;
    assign disp      = rdy_in && !flush_in && count_q != '0 && rob_avail && (to_rs ? rs_avail : lsb_avail);
    assign enq       = rdy_in && !flush_in && dec_valid && dec_ready;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        head_d  = flush_in ? '0 : disp ? head_q + 1'b1 : head_q;
        tail_d  = flush_in ? '0 : enq ? tail_q + 1'b1 : tail_q;
        count_d = flush_in ? '0 : count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, disp};
    end

    // Pointer registers advance only while the core is enabled
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: enqueue write at tail, pop at head, wake-up on every live entry
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
            q1_q    <= '0;
            q2_q    <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                op_q[e]  <= '0;
                rd_q[e]  <= '0;
                imm_q[e] <= '0;
                pc_q[e]  <= '0;
                v1_q[e]  <= '0;
                v2_q[e]  <= '0;
            end
        end else if (rdy_in) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (flush_in) begin
                    valid_q[e] <= 1'b0;
                end else if (enq && tail_q == PW'(e)) begin
                    valid_q[e] <= 1'b1;
                    op_q[e]    <= dec_op;
                    rd_q[e]    <= dec_rd;
                    imm_q[e]   <= dec_imm;
                    pc_q[e]    <= dec_pc;
                    q1_q[e]    <= eq1;
                    v1_q[e]    <= ev1;
                    q2_q[e]    <= eq2;
                    v2_q[e]    <= ev2;
                end else begin
                    if (disp && head_q == PW'(e))
                        valid_q[e] <= 1'b0;
                    if (valid_q[e]) begin
                        q1_q[e] <= w_q1[e];
                        v1_q[e] <= w_v1[e];
                        q2_q[e] <= w_q2[e];
                        v2_q[e] <= w_v2[e];
                    end
                end
            end
        end
    end

    // Issue registers: pulse iss_valid per dispatch, hold payload until the next one
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            iss_valid  <= 1'b0;
            iss_to_rs  <= 1'b0;
            iss_to_lsb <= 1'b0;
            iss_lock   <= 1'b0;
            iss_op     <= '0;
            iss_rd     <= '0;
            iss_imm    <= '0;
            iss_pc     <= '0;
            iss_robtag <= '0;
            iss_vj     <= '0;
            iss_vk     <= '0;
            iss_qj     <= 1'b0;
            iss_qk     <= 1'b0;
            iss_tj     <= '0;
            iss_tk     <= '0;
        end else begin
            iss_valid <= disp;
            if (disp) begin
                iss_to_rs  <= to_rs;
                iss_to_lsb <= !to_rs;
                iss_lock   <= (head_cls == CLS_ALU || head_cls == CLS_LD) && rd_q[head_q] != 5'd0;
                iss_op     <= op_q[head_q];
                iss_rd     <= rd_q[head_q];
                iss_imm    <= imm_q[head_q];
                iss_pc     <= pc_q[head_q];
                iss_robtag <= rob_tag;
                iss_vj     <= w_v1[head_q];
                iss_vk     <= w_v2[head_q];
                iss_qj     <= w_q1[head_q];
                iss_qk     <= w_q2[head_q];
                iss_tj     <= w_q1[head_q] ? w_v1[head_q][ROB_W-1:0] : '0;
                iss_tk     <= w_q2[head_q] ? w_v2[head_q][ROB_W-1:0] : '0;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random stimulus against a queue-based reference model
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4, ROB_W = 4, DATA_W = 32, CDB_N = 2;

    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic dec_valid = 1'b0, dec_ready;
    logic [OP_W-1:0] dec_op = '0;
    logic [4:0] dec_rd = '0;
    logic [31:0] dec_imm = '0, dec_pc = '0;
    logic dec_rs1_q = 1'b0, dec_rs2_q = 1'b0;
    logic [DATA_W-1:0] dec_rs1_v = '0, dec_rs2_v = '0;
    logic [CDB_N-1:0] cdb_valid = '0;
    logic [CDB_N*ROB_W-1:0] cdb_tag = '0;
    logic [CDB_N*DATA_W-1:0] cdb_val = '0;
    logic rob_avail = 1'b1, rs_avail = 1'b1, lsb_avail = 1'b1;
    logic [ROB_W-1:0] rob_tag = '0;
    logic iss_valid, iss_to_rs, iss_to_lsb, iss_lock, iss_qj, iss_qk;
    logic [OP_W-1:0] iss_op;
    logic [4:0] iss_rd;
    logic [31:0] iss_imm, iss_pc;
    logic [ROB_W-1:0] iss_robtag, iss_tj, iss_tk;
    logic [DATA_W-1:0] iss_vj, iss_vk;

    issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_rs1_q(dec_rs1_q), .dec_rs2_q(dec_rs2_q),
        .dec_rs1_v(dec_rs1_v), .dec_rs2_v(dec_rs2_v), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .rob_avail(rob_avail), .rs_avail(rs_avail), .lsb_avail(lsb_avail),
        .rob_tag(rob_tag), .iss_valid(iss_valid), .iss_to_rs(iss_to_rs), .iss_to_lsb(iss_to_lsb),
        .iss_lock(iss_lock), .iss_op(iss_op), .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_robtag(iss_robtag), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .iss_tj(iss_tj), .iss_tk(iss_tk));

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [4:0] rd;
        logic [31:0] imm, pc;
        logic q1, q2;
        logic [31:0] v1, v2;
    } ent_t;

    ent_t mq[$];
    logic e_valid, e_rs, e_lsb, e_lock, e_qj, e_qk;
    logic [OP_W-1:0] e_op;
    logic [4:0] e_rd;
    logic [31:0] e_imm, e_pc, e_vj, e_vk;
    logic [ROB_W-1:0] e_tag, e_tj, e_tk;
    int total = 0, bad = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mem(logic [OP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit no_lock(logic [OP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic [32:0] wk(logic q, logic [31:0] v);
        if (q)
            for (int i = 0; i < CDB_N; i++)
                if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == v[ROB_W-1:0])
                    return {1'b0, cdb_val[i*DATA_W +: DATA_W]};
        return {q, v};
    endfunction

    function automatic void model_clear_iss();
        {e_valid, e_rs, e_lsb, e_lock, e_qj, e_qk} = '0;
        e_op = '0; e_rd = '0; e_imm = '0; e_pc = '0; e_vj = '0; e_vk = '0;
        e_tag = '0; e_tj = '0; e_tk = '0;
    endfunction

    function automatic void model_step();
        ent_t h, n;
        bit ready;
        e_valid = 1'b0;
        if (!rdy_in) return;
        if (flush_in) begin
            mq.delete();
            return;
        end
        ready = mq.size() != DEPTH;
        if (mq.size() != 0 && rob_avail && (is_mem(mq[0].op) ? lsb_avail : rs_avail)) begin
            h = mq.pop_front();
            {h.q1, h.v1} = wk(h.q1, h.v1);
            {h.q2, h.v2} = wk(h.q2, h.v2);
            e_valid = 1'b1;
            e_rs = !is_mem(h.op);
            e_lsb = is_mem(h.op);
            e_lock = !no_lock(h.op) && h.rd != 0;
            e_op = h.op; e_rd = h.rd; e_imm = h.imm; e_pc = h.pc; e_tag = rob_tag;
            e_vj = h.v1; e_vk = h.v2; e_qj = h.q1; e_qk = h.q2;
            e_tj = h.q1 ? h.v1[ROB_W-1:0] : '0;
            e_tk = h.q2 ? h.v2[ROB_W-1:0] : '0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            n = mq[i];
            {n.q1, n.v1} = wk(n.q1, n.v1);
            {n.q2, n.v2} = wk(n.q2, n.v2);
            mq[i] = n;
        end
        if (dec_valid && ready) begin
            n.op = dec_op; n.rd = dec_rd; n.imm = dec_imm; n.pc = dec_pc;
            {n.q1, n.v1} = wk(dec_rs1_q, dec_rs1_v);
            {n.q2, n.v2} = wk(dec_rs2_q, dec_rs2_v);
            mq.push_back(n);
        end
    endfunction

    task automatic check_all();
        chk("dec_ready", dec_ready, mq.size() != DEPTH);
        chk("iss_valid", iss_valid, e_valid);
        chk("iss_to_rs", iss_to_rs, e_rs);
        chk("iss_to_lsb", iss_to_lsb, e_lsb);
        chk("iss_lock", iss_lock, e_lock);
        chk("iss_op", iss_op, e_op);
        chk("iss_rd", iss_rd, e_rd);
        chk("iss_imm", iss_imm, e_imm);
        chk("iss_pc", iss_pc, e_pc);
        chk("iss_robtag", iss_robtag, e_tag);
        chk("iss_vj", iss_vj, e_vj);
        chk("iss_vk", iss_vk, e_vk);
        chk("iss_qj", iss_qj, e_qj);
        chk("iss_qk", iss_qk, e_qk);
        chk("iss_tj", iss_tj, e_tj);
        chk("iss_tk", iss_tk, e_tk);
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        check_all();
        rob_tag = ROB_W'($urandom);
    endtask

    task automatic set_dec(logic [OP_W-1:0] op, logic [4:0] rd, logic q1, logic [31:0] v1, logic q2, logic [31:0] v2);
        dec_valid = 1'b1; dec_op = op; dec_rd = rd; dec_imm = $urandom; dec_pc = $urandom;
        dec_rs1_q = q1; dec_rs1_v = v1; dec_rs2_q = q2; dec_rs2_v = v2;
    endtask

    task automatic idle();
        dec_valid = 1'b0; cdb_valid = '0; flush_in = 1'b0;
    endtask

    task automatic wait_issue(string tag);
        for (int n = 0; n < 8 && iss_valid !== 1'b1; n++) tick();
        chk({tag, "_issued"}, iss_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [OP_W-1:0] ops [8];
        ops = '{OP_ADDI, OP_ADD, OP_LUI, OP_JAL, OP_BEQ, OP_LW, OP_SW, OP_SB};
        model_clear_iss();
        #12;
        chk("rst_valid", iss_valid, 0);
        chk("rst_ready", dec_ready, 1);
        chk("rst_lock", iss_lock, 0);
        chk("rst_pc", iss_pc, 0);
        chk("rst_vj", iss_vj, 0);
        rst_in = 1'b0;

        // back-to-back ALU ops
        for (int i = 1; i <= 4; i++) begin
            set_dec(OP_ADDI, 5'(i), 1'b0, $urandom, 1'b0, $urandom);
            tick();
        end
        idle();
        chk("t1_rd", iss_rd, 3);
        chk("t1_lock", iss_lock, 1);
        tick(); tick(); tick();

        // fill while RS is blocked, then drain
        rs_avail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_dec(OP_ADD, 5'(10 + i), 1'b0, $urandom, 1'b0, $urandom);
            tick();
        end
        chk("t2_full", dec_ready, 0);
        set_dec(OP_ADD, 5'd20, 1'b0, 1, 1'b0, 2);
        tick();
        idle();
        rs_avail = 1'b1;
        tick();
        chk("t2_first", iss_rd, 10);
        for (int i = 0; i < 4; i++) tick();

        // wake-up of a buffered operand on channel 1
        rs_avail = 1'b0;
        set_dec(OP_ADD, 5'd6, 1'b1, 32'd5, 1'b0, 32'h55);
        tick();
        idle();
        tick(); tick(); tick();
        cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_val = {32'h1234, 32'hdead};
        tick();
        idle();
        rs_avail = 1'b1;
        wait_issue("t3");
        chk("t3_qj", iss_qj, 0);
        chk("t3_vj", iss_vj, 32'h1234);
        tick();

        // broadcast in the enqueue cycle
        set_dec(OP_ADD, 5'd7, 1'b0, 32'h1, 1'b1, 32'd7);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_val = {32'h0, 32'habc};
        tick();
        idle();
        wait_issue("t4a");
        chk("t4a_qk", iss_qk, 0);
        chk("t4a_vk", iss_vk, 32'habc);
        tick();

        // broadcast in the dispatch cycle, both channels match, lowest wins
        rs_avail = 1'b0;
        set_dec(OP_ADD, 5'd8, 1'b0, 32'h2, 1'b1, 32'd7);
        tick();
        idle();
        tick();
        rs_avail = 1'b1;
        cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_val = {32'h888, 32'h777};
        tick();
        idle();
        chk("t4b_valid", iss_valid, 1);
        chk("t4b_qk", iss_qk, 0);
        chk("t4b_vk", iss_vk, 32'h777);
        tick();

        // store to LSB while RS is full; branch waits for RS
        rs_avail = 1'b0; lsb_avail = 1'b1;
        set_dec(OP_SW, 5'd3, 1'b0, 32'h10, 1'b0, 32'h20);
        tick();
        idle();
        wait_issue("t5_sw");
        chk("t5_lsb", iss_to_lsb, 1);
        chk("t5_lock", iss_lock, 0);
        set_dec(OP_BEQ, 5'd0, 1'b0, 32'h1, 1'b0, 32'h1);
        tick();
        idle();
        tick(); tick(); tick();
        chk("t5_beq_hold", iss_valid, 0);
        rs_avail = 1'b1;
        wait_issue("t5_beq");
        chk("t5_beq_rs", iss_to_rs, 1);
        tick();

        // flush with a concurrent decode
        rs_avail = 1'b0; lsb_avail = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_dec(OP_ADD, 5'(i + 1), 1'b0, $urandom, 1'b0, $urandom);
            tick();
        end
        set_dec(OP_ADD, 5'd9, 1'b0, 1, 1'b0, 2);
        flush_in = 1'b1;
        tick();
        idle();
        chk("t6_ready", dec_ready, 1);
        rs_avail = 1'b1; lsb_avail = 1'b1;
        tick();
        chk("t6_noiss", iss_valid, 0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rdy_in = $urandom_range(0, 9) != 0;
            flush_in = $urandom_range(0, 39) == 0;
            rob_avail = $urandom_range(0, 3) != 0;
            rs_avail = $urandom_range(0, 3) != 0;
            lsb_avail = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) != 0)
                set_dec(ops[$urandom_range(0, 7)], 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
            else
                dec_valid = 1'b0;
            cdb_valid = CDB_N'($urandom);
            cdb_tag = (CDB_N*ROB_W)'($urandom);
            cdb_val = {$urandom, $urandom};
            tick();
        end
        idle();
        rdy_in = 1'b1;

        // asynchronous reset mid-operation
        rs_avail = 1'b1; lsb_avail = 1'b1; rob_avail = 1'b1;
        set_dec(OP_LW, 5'd4, 1'b0, 32'h3, 1'b0, 32'h4);
        tick();
        set_dec(OP_ADDI, 5'd5, 1'b0, 32'h3, 1'b0, 32'h4);
        tick();
        idle();
        rs_avail = 1'b0;
        tick();
        #2;
        rst_in = 1'b1;
        #1;
        mq.delete();
        model_clear_iss();
        chk("arst_ready", dec_ready, 1);
        chk("arst_valid", iss_valid, 0);
        chk("arst_pc", iss_pc, 0);
        rst_in = 1'b0;
        rs_avail = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
